// File: rtl/std_io_bidir_pkg.sv
// Shared types and width helpers for the bit-serial bidirectional pin sequencer.
package std_io_bidir_pkg;

   // Sequencer phases. The write path runs IDLE-TX-REL-GUARD-DONE.
   // The read path runs IDLE-REL-GUARD-RX-DONE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TX    = 3'd1,
      REL   = 3'd2,
      GUARD = 3'd3,
      RX    = 3'd4,
      DONE  = 3'd5
   } io_seq_state_e;

   // Largest guard time the sequencer is built for.
   localparam int TURN_CYC_MAX = 255;

   // Bits needed to hold the values 0..max_val (never less than one bit).
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/std_sync2.sv
// Two-flop synchronizer for the raw pin input. Both stages clear on clrn so the
// sequencer never sees a stale pin value right after reset.
module std_sync2 (
   input  logic clk,
   input  logic clrn,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops.
   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: non-blocking assignments let both stages sample their old values on
      // the same edge; blocking ones would collapse the chain into a single flop.
      if (!clrn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/std_io_bidir_seq.sv
// Half-duplex bit-serial sequencer for one shared bidirectional pin.
// Writes shift a word out MSB first through a registered tri-state IO cell;
// reads release the pin, wait out the turnaround guard and sample a word in.
// The io_* outputs are registered so ena, drv and data always change together
// on the clock edge the IO-cell register sees.
module std_io_bidir_seq
   import std_io_bidir_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DIV_W    = 16,
   parameter int TURN_CYC = 2
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic [DIV_W-1:0]  bit_div,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rd,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              io_ena,
   output logic              io_drv,
   output logic              io_data,
   input  logic              io_in
);

   // Bit counter holds 0..DATA_W, guard counter holds 0..TURN_CYC.
   localparam int BIT_CNT_W = cnt_w(DATA_W);
   localparam int GUARD_W   = cnt_w(TURN_CYC);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(DATA_W - 1);
   localparam logic [GUARD_W-1:0]   LAST_GUARD = GUARD_W'(TURN_CYC - 1);

   // ------------------------------------------------------------------------
   // Registers (_q) and their next values (_d)
   // ------------------------------------------------------------------------
   io_seq_state_e          state_q,     state_d;
   logic [DIV_W-1:0]       div_lat_q,   div_lat_d;     // bit_div latched at accept
   logic                   rd_lat_q,    rd_lat_d;      // cmd_rd latched at accept
   logic [DIV_W-1:0]       div_cnt_q,   div_cnt_d;     // clock within current bit
   logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;     // bit index within word
   logic [GUARD_W-1:0]     guard_cnt_q, guard_cnt_d;   // clock within guard time
   logic [DATA_W-1:0]      shift_q,     shift_d;       // tx word or rx capture
   logic [DATA_W-1:0]      rsp_data_q,  rsp_data_d;
   logic                   io_ena_q,    io_ena_d;
   logic                   io_drv_q,    io_drv_d;
   logic                   io_data_q,   io_data_d;
   logic                   rst_done_q;                 // low until first clock after reset

   // ------------------------------------------------------------------------
   // Decodes
   // ------------------------------------------------------------------------
   logic                   io_in_sync;
   logic                   accept;
   logic                   bit_end;
   logic                   last_bit;
   logic                   sample_pt;
   logic [DATA_W-1:0]      shift_tx;
   logic [DATA_W-1:0]      shift_rx;

   std_sync2 u_sync (
      .clk  (clk),
      .clrn (clrn),
      .d    (io_in),
      .q    (io_in_sync)
   );

   assign cmd_ready = (state_q == IDLE) && rst_done_q;
   assign accept    = cmd_valid && cmd_ready;

   // The divider counts up to the latched value, so it can never wrap.
   assign bit_end   = (div_cnt_q == div_lat_q);
   assign last_bit  = (bit_cnt_q == LAST_BIT);
   assign sample_pt = (div_cnt_q == (div_lat_q >> 1));

   // Next transmit word exposes the following bit at the MSB; the receive word
   // takes the synchronized pin value in at the LSB.
   assign shift_tx  = shift_q << 1;
   assign shift_rx  = (shift_q << 1) | DATA_W'(io_in_sync);

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = rsp_data_q;
   assign io_ena    = io_ena_q;
   assign io_drv    = io_drv_q;
   assign io_data   = io_data_q;

   // Next-state, counter, shift-register and IO-control logic.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      div_lat_d   = div_lat_q;
      rd_lat_d    = rd_lat_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      guard_cnt_d = guard_cnt_q;
      shift_d     = shift_q;
      rsp_data_d  = rsp_data_q;
      io_ena_d    = 1'b0;          // strobe only on the clocks named below
      io_drv_d    = io_drv_q;      // drive control and data hold between strobes
      io_data_d   = io_data_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               div_lat_d   = bit_div;
               rd_lat_d    = cmd_rd;
               div_cnt_d   = '0;
               bit_cnt_d   = '0;
               guard_cnt_d = '0;
               io_ena_d    = 1'b1;
               if (cmd_rd) begin
                  // Read: release the pin right away.
                  shift_d  = '0;
                  io_drv_d = 1'b0;
                  state_d  = REL;
               end else begin
                  // Write: first strobe carries the MSB.
                  shift_d   = cmd_data;
                  io_drv_d  = 1'b1;
                  io_data_d = cmd_data[DATA_W-1];
                  state_d   = TX;
               end
            end
         end

         TX: begin
            if (bit_end) begin
               div_cnt_d = '0;
               io_ena_d  = 1'b1;
               if (last_bit) begin
                  // Last bit period is over: release the pin.
                  io_drv_d = 1'b0;
                  state_d  = REL;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  shift_d   = shift_tx;
                  io_data_d = shift_tx[DATA_W-1];
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         REL: begin
            // The release strobe was issued on the way in; now wait out the guard.
            guard_cnt_d = '0;
            state_d     = GUARD;
         end

         GUARD: begin
            if (guard_cnt_q == LAST_GUARD) begin
               guard_cnt_d = '0;
               div_cnt_d   = '0;
               bit_cnt_d   = '0;
               if (rd_lat_q) begin
                  state_d = RX;
               end else begin
                  rsp_data_d = '0;     // writes report an all-zero word
                  state_d    = DONE;
               end
            end else begin
               guard_cnt_d = guard_cnt_q + GUARD_W'(1);
            end
         end

         RX: begin
            // Sample near mid-bit; with bit_div = 0 sampling and bit end coincide.
            if (sample_pt) begin
               shift_d = shift_rx;
            end
            if (bit_end) begin
               div_cnt_d = '0;
               if (last_bit) begin
                  rsp_data_d = shift_d;  // includes this clock's sample
                  state_d    = DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         DONE: begin
            // rsp_valid is high for exactly this one clock.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; everything returns to its idle value on clrn,
   // which also releases the pin and drops any command in flight.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= IDLE;
         div_lat_q   <= '0;
         rd_lat_q    <= 1'b0;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         guard_cnt_q <= '0;
         shift_q     <= '0;
         rsp_data_q  <= '0;
         io_ena_q    <= 1'b0;
         io_drv_q    <= 1'b0;
         io_data_q   <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_lat_q   <= div_lat_d;
         rd_lat_q    <= rd_lat_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         guard_cnt_q <= guard_cnt_d;
         shift_q     <= shift_d;
         rsp_data_q  <= rsp_data_d;
         io_ena_q    <= io_ena_d;
         io_drv_q    <= io_drv_d;
         io_data_q   <= io_data_d;
         rst_done_q  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_std_io_bidir_seq.sv
// Self-checking bench for std_io_bidir_seq: reset values, a table of directed
// commands, randomized commands against a timing/data reference model, busy
// command churn, a mid-write reset abort, and guard-time latency on two builds.
module tb_std_io_bidir_seq;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 16;
   localparam int TURN   = 2;

   logic              clk;
   logic              clrn;
   logic [DIV_W-1:0]  bit_div;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rd;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   logic              io_ena;
   logic              io_drv;
   logic              io_data;
   logic              io_in;

   // Second and third builds, used only for guard-time latency.
   logic              lat_valid;
   logic              t1_ready, t1_rsp, t1_busy, t1_ena, t1_drv, t1_dat;
   logic              t4_ready, t4_rsp, t4_busy, t4_ena, t4_drv, t4_dat;
   logic [DATA_W-1:0] t1_rdata, t4_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   std_io_bidir_seq #(.DATA_W(DATA_W), .DIV_W(DIV_W), .TURN_CYC(TURN)) dut (
      .clk(clk), .clrn(clrn), .bit_div(bit_div), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .io_ena(io_ena), .io_drv(io_drv), .io_data(io_data), .io_in(io_in)
   );

   std_io_bidir_seq #(.DATA_W(DATA_W), .DIV_W(DIV_W), .TURN_CYC(1)) dut_t1 (
      .clk(clk), .clrn(clrn), .bit_div(bit_div), .cmd_valid(lat_valid),
      .cmd_ready(t1_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
      .rsp_valid(t1_rsp), .rsp_data(t1_rdata), .busy(t1_busy),
      .io_ena(t1_ena), .io_drv(t1_drv), .io_data(t1_dat), .io_in(1'b0)
   );

   std_io_bidir_seq #(.DATA_W(DATA_W), .DIV_W(DIV_W), .TURN_CYC(4)) dut_t4 (
      .clk(clk), .clrn(clrn), .bit_div(bit_div), .cmd_valid(lat_valid),
      .cmd_ready(t4_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
      .rsp_valid(t4_rsp), .rsp_data(t4_rdata), .busy(t4_busy),
      .io_ena(t4_ena), .io_drv(t4_drv), .io_data(t4_dat), .io_in(1'b0)
   );

   // ---------------------------------------------------------------------
   // Pin model: registered IO cell plus an external device that drives the
   // pin while it is released. The device presents bit k of its word for one
   // bit period, starting two clocks before RX bit k begins, so the sample
   // (pin state two cycles before the sampling cycle) lands inside it.
   // ---------------------------------------------------------------------
   logic              pin_drv, pin_val, ext_val;
   bit                dev_on;
   int                dev_start, dev_d, dev_off;
   logic [DATA_W-1:0] dev_word;

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pin_drv <= 1'b0;
         pin_val <= 1'b0;
      end else if (io_ena) begin
         pin_drv <= io_drv;
         pin_val <= io_data;
      end
   end

   always_comb begin
      ext_val = 1'b0;
      dev_off = cyc - dev_start;
      if (dev_on && dev_off >= 0 && dev_off < DATA_W * dev_d)
         ext_val = dev_word[DATA_W - 1 - dev_off / dev_d];
   end

   assign io_in = pin_drv ? pin_val : ext_val;

   // ---------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one command (call just after a falling edge) and check it against
   // the timing rules. Returns at the falling edge one clock after rsp_valid.
   task automatic do_cmd(input logic rd, input logic [7:0] data, input logic [15:0] div,
                         input logic [7:0] ext, input bit churn,
                         output int acc_abs, output int rsp_abs, output logic [7:0] rsp_word);
      int   d, wait_n, limit, exp_rel, n;
      bit   ready_bad, busy_bad, drv_bad, got_rsp;
      int   s_rel[$], e_rel[$];
      logic s_drv[$], s_dat[$], e_drv[$], e_dat[$];

      d        = int'(div) + 1;
      acc_abs  = -1;
      rsp_abs  = -1;
      rsp_word = 'x;
      bit_div  = div;
      cmd_rd   = rd;
      cmd_data = data;
      cmd_valid = 1'b1;
      wait_n   = 0;
      while (!cmd_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 64'(0), 64'(1));
         cmd_valid = 1'b0;
         return;
      end
      acc_abs = cyc;

      // Reference: strobe list and completion time from the timing rules.
      if (rd) begin
         dev_start = acc_abs + 2 + TURN - 2;
         dev_d     = d;
         dev_word  = ext;
         dev_on    = 1'b1;
         e_rel.push_back(1); e_drv.push_back(1'b0); e_dat.push_back(1'b0);
         exp_rel = 2 + TURN + DATA_W * d;
      end else begin
         for (int k = 0; k < DATA_W; k++) begin
            e_rel.push_back(1 + k * d); e_drv.push_back(1'b1); e_dat.push_back(data[DATA_W-1-k]);
         end
         e_rel.push_back(1 + DATA_W * d); e_drv.push_back(1'b0); e_dat.push_back(1'b0);
         exp_rel = 2 + DATA_W * d + TURN;
      end

      limit = exp_rel + 20;
      got_rsp = 0; ready_bad = 0; busy_bad = 0; drv_bad = 0;
      for (int rel = 1; rel <= limit && !got_rsp; rel++) begin
         @(negedge clk);
         if (churn) begin
            cmd_data = 8'($urandom);
            bit_div  = 16'($urandom_range(0, 20));
            cmd_rd   = 1'($urandom);
         end
         if (io_ena) begin
            s_rel.push_back(rel); s_drv.push_back(io_drv); s_dat.push_back(io_data);
         end
         if (rd && io_drv !== 1'b0) drv_bad = 1;
         if (cmd_ready !== 1'b0) ready_bad = 1;
         if (busy !== 1'b1) busy_bad = 1;
         if (rsp_valid) begin
            got_rsp   = 1;
            rsp_abs   = cyc;
            rsp_word  = rsp_data;
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;

      if (!got_rsp) check("rsp_timeout", 64'(0), 64'(1));
      else          check("rsp_latency", 64'(rsp_abs - acc_abs), 64'(exp_rel));
      check("rsp_data", 64'(rsp_word), rd ? 64'(ext) : 64'(0));
      check("busy_ready_while_active", 64'({busy_bad, ready_bad}), 64'(0));
      if (rd) check("drv_released_in_read", 64'(drv_bad), 64'(0));
      check("strobe_count", 64'(s_rel.size()), 64'(e_rel.size()));
      n = (s_rel.size() < e_rel.size()) ? s_rel.size() : e_rel.size();
      for (int i = 0; i < n; i++)
         check("strobe", 64'({s_rel[i], s_drv[i], s_drv[i] & s_dat[i]}),
               64'({e_rel[i], e_drv[i], e_dat[i]}));
      dev_on = 1'b0;

      @(negedge clk);
      check("ready_after_rsp", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
      check("rsp_data_holds", 64'(rsp_data), 64'(rsp_word));
   endtask

   // ---------------------------------------------------------------------
   typedef struct {
      logic       rd;
      logic [7:0] data;
      logic [15:0] div;
      logic [7:0] ext;
      int         exp_rel;
      logic [7:0] exp_data;
   } vec_t;

   initial begin
      vec_t       vecs[7];
      int         acc, rsp, prev_rsp, wait_n, lat_acc, t1_rel, t4_rel;
      logic [7:0] word;
      bit         saw_rsp;
      logic       r_rd;
      logic [7:0] r_data, r_ext;
      logic [15:0] r_div;
      bit         r_churn;

      clrn = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_data = '0; bit_div = '0;
      lat_valid = 1'b0; dev_on = 1'b0; dev_start = 0; dev_d = 1; dev_word = '0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_data",  64'(rsp_data),  64'(0));
      check("rst_io",        64'({io_ena, io_drv, io_data}), 64'(0));
      clrn = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

      // Directed table, run back to back (bit_div 0 write then read included).
      vecs[0] = '{1'b0, 8'hA5, 16'd3, 8'h00, 36, 8'h00};
      vecs[1] = '{1'b1, 8'h00, 16'd7, 8'h3C, 68, 8'h3C};
      vecs[2] = '{1'b0, 8'h00, 16'd1, 8'h00, 20, 8'h00};
      vecs[3] = '{1'b1, 8'h77, 16'd3, 8'hC3, 36, 8'hC3};
      vecs[4] = '{1'b0, 8'hFF, 16'd0, 8'h00, 12, 8'h00};
      vecs[5] = '{1'b1, 8'h00, 16'd0, 8'h5A, 12, 8'h5A};
      vecs[6] = '{1'b0, 8'h81, 16'd4, 8'h00, 44, 8'h00};
      prev_rsp = 0;
      for (int i = 0; i < 7; i++) begin
         do_cmd(vecs[i].rd, vecs[i].data, vecs[i].div, vecs[i].ext, 1'b0, acc, rsp, word);
         check("vec_latency", 64'(rsp - acc), 64'(vecs[i].exp_rel));
         check("vec_data",    64'(word),      64'(vecs[i].exp_data));
         if (i > 0) check("b2b_idle_gap", 64'(acc - prev_rsp), 64'(1));
         prev_rsp = rsp;
      end

      // Command inputs churn while busy: only the latched word/divider count.
      do_cmd(1'b0, 8'h3C, 16'd2, 8'h00, 1'b1, acc, rsp, word);
      @(negedge clk);
      check("no_second_accept", 64'({busy, rsp_valid}), 64'(0));

      // Randomized commands against the reference model.
      for (int i = 0; i < 16; i++) begin
         r_rd    = 1'($urandom);
         r_data  = 8'($urandom);
         r_ext   = 8'($urandom);
         r_div   = 16'($urandom_range(3, 6));
         r_churn = ($urandom_range(0, 3) == 0);
         do_cmd(r_rd, r_data, r_div, r_ext, r_churn, acc, rsp, word);
      end

      // Reset at the bit-4 strobe of a write.
      bit_div = 16'd3; cmd_rd = 1'b0; cmd_data = 8'hA5; cmd_valid = 1'b1;
      wait_n = 0;
      while (!cmd_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
      acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_n = 0;
      while (cyc - acc < 17 && wait_n < 40) begin @(negedge clk); wait_n++; end
      check("bit4_strobe", 64'({io_ena, io_drv, io_data}), 64'(3'b110));
      #2 clrn = 1'b0;
      #1;
      check("abort_ctrl", 64'({cmd_ready, busy, rsp_valid, io_ena, io_drv, io_data}), 64'(0));
      check("abort_rsp_data", 64'(rsp_data), 64'(0));
      saw_rsp = 0;
      repeat (2) begin @(negedge clk); if (rsp_valid) saw_rsp = 1; end
      clrn = 1'b1;
      repeat (30) begin @(negedge clk); if (rsp_valid) saw_rsp = 1; end
      check("abort_no_rsp", 64'(saw_rsp), 64'(0));
      do_cmd(1'b0, 8'h5A, 16'd3, 8'h00, 1'b0, acc, rsp, word);
      do_cmd(1'b1, 8'h00, 16'd3, 8'h96, 1'b0, acc, rsp, word);

      // Guard time: TURN_CYC=1 vs 4, read with bit_div=5.
      bit_div = 16'd5; cmd_rd = 1'b1; cmd_data = 8'h00; lat_valid = 1'b1;
      wait_n = 0;
      while (!(t1_ready && t4_ready) && wait_n < 50) begin @(negedge clk); wait_n++; end
      lat_acc = cyc; t1_rel = -1; t4_rel = -1;
      for (int n = 1; n <= 120 && (t1_rel < 0 || t4_rel < 0); n++) begin
         @(negedge clk);
         lat_valid = 1'b0;
         if (t1_rsp && t1_rel < 0) t1_rel = cyc - lat_acc;
         if (t4_rsp && t4_rel < 0) t4_rel = cyc - lat_acc;
      end
      check("turn1_latency", 64'(t1_rel), 64'(51));
      check("turn4_latency", 64'(t4_rel), 64'(54));
      check("turn_delta",    64'(t4_rel - t1_rel), 64'(3));
      repeat (6) @(negedge clk);
      check("turn1_idle", 64'({t1_ready, t1_busy, t1_ena, t1_drv, t1_dat, t1_rdata}), 64'({5'b10000, 8'h00}));
      check("turn4_idle", 64'({t4_ready, t4_busy, t4_ena, t4_drv, t4_dat, t4_rdata}), 64'({5'b10000, 8'h00}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete (total=%0d bad=%0d)", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/std_io_bidir_seq.md
# std_io_bidir_seq

Half-duplex bit-serial sequencer for one shared bidirectional pin. It takes write/read commands through a valid/ready handshake and shifts `DATA_W`-bit words out on the pin, or samples them in. It drives the `ena`/`drv`/`data` controls of a registered tri-state IO cell and inserts release/turnaround guard time between directions. It sits between a command master (CPU bridge or protocol engine) and the IO-cell register instance.

## Interface
Parameters:
- `DATA_W`, 8: bits per word, MSB first.
- `DIV_W`, 16: width of the bit-period divider.
- `TURN_CYC`, 2: guard clocks with the pin released, range 1..255.

Ports:
- `clk`  in  1  sole clock.
- `clrn`  in  1  asynchronous, active-low reset.
- `bit_div`  in  DIV_W  clocks per bit minus 1; latched at command accept.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_rd`  in  1  1 = read word, 0 = write word.
- `cmd_data`  in  DATA_W  word to transmit; ignored for reads.
- `rsp_valid`  out  1  one-clock completion pulse.
- `rsp_data`  out  DATA_W  received word; 0 for writes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `io_ena`  out  1  update strobe to the IO-cell register.
- `io_drv`  out  1  1 = drive the pin, 0 = release (Z).
- `io_data`  out  1  value to drive.
- `io_in`  in  1  raw pin value; synchronized internally.

## Operation
- Reset values: `cmd_ready`=0 during reset and 1 afterwards. `rsp_valid`=0, `rsp_data`=0, `busy`=0, `io_ena`=0, `io_drv`=0, `io_data`=0. State is IDLE.
- States: IDLE, TX, REL, GUARD, RX, DONE.
- `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid & cmd_ready`. On accept, latch `bit_div`, `cmd_data` and `cmd_rd`.
- Write path: IDLE → TX.
  - Each bit lasts `bit_div`+1 clocks.
  - On the first clock of bit k: `io_ena`=1, `io_drv`=1, `io_data`=bit (DATA_W-1-k).
  - After the last bit period: REL, one clock with `io_ena`=1 and `io_drv`=0.
  - Then GUARD for `TURN_CYC` clocks, then DONE.
- Read path: IDLE → REL → GUARD (`TURN_CYC` clocks) → RX.
  - Each RX bit lasts `bit_div`+1 clocks.
  - Sample the synchronized `io_in` at in-bit offset floor(`bit_div`/2). Shift in MSB first.
  - After the last bit period, go to DONE.
- DONE: one clock with `rsp_valid`=1, then IDLE.
  - `rsp_data` = shift register for reads, 0 for writes.
  - `rsp_data` holds until the next DONE.
- `io_ena` is 0 on every clock not listed above. `io_drv`/`io_data` hold their last value.
- Bit counter width is clog2(DATA_W+1). The divider counter is DIV_W bits and counts from 0 up to the latched `bit_div`. It never wraps, because it is compared against the latched value.
- `rsp_valid` has no backpressure. The master must consume it on the pulse.
- `clrn` asserted mid-operation: immediate return to reset values, the pin is released, and no `rsp_valid` is issued for the aborted command.
- Changes to `cmd_*` or `bit_div` while busy are ignored.

## Timing
- Accept at clock 0, with D = `bit_div`+1.
- Write:
  - Bit k strobe at clock 1+k·D.
  - REL at 1+DATA_W·D.
  - `rsp_valid` at 2+DATA_W·D+TURN_CYC.
- Read:
  - REL at 1.
  - RX bit k begins at 2+TURN_CYC+k·D.
  - Sample at that begin + floor(`bit_div`/2).
  - `rsp_valid` at 2+TURN_CYC+DATA_W·D.
- `cmd_ready` returns to 1 the clock after `rsp_valid`. Back-to-back commands are therefore spaced by one IDLE clock.
- The IO-cell register adds one clock from strobe to pin. The 2-flop synchronizer adds two clocks of `io_in` latency. A pin sample reflects pin state three clocks before the sample edge. Masters choose `bit_div` ≥ 3 for loopback correctness.

## Structure
- Package `std_io_bidir_pkg` holds:
  - the state enum `io_seq_state_e` (IDLE, TX, REL, GUARD, RX, DONE);
  - localparam helpers for counter widths.
- Sub-module `std_sync2`: 2-flop synchronizer for `io_in`, reset to 0 on `clrn`.
- FSM, divider, bit counter and shift register live in the top module.
- The IO-cell register is instantiated by the parent, not inside this block.

## Test plan
- Write, `DATA_W`=8, `bit_div`=3, `cmd_data`=0xA5:
  - strobes at clocks 1, 5, …, 29 carry 1,0,1,0,0,1,0,1 with `io_drv`=1;
  - REL at 33;
  - `rsp_valid` at 36 with `rsp_data`=0;
  - `cmd_ready` back at 37.
- Read, `bit_div`=7, with the pin model returning 0x3C through the IO register: `rsp_valid` at 68 with `rsp_data`=0x3C, and `io_drv`=0 throughout.
- `bit_div`=0, write 0xFF then an immediate read: one IDLE clock between them, REL asserted before any RX sample, `io_drv` never 1 during RX.
- `cmd_valid` held while busy with changing `cmd_data` and `bit_div`: no second accept, and the transmitted bits match the latched word.
- `clrn` pulsed at the bit-4 strobe of a write: all outputs reach reset values asynchronously, no `rsp_valid`, and the next command behaves normally.
- `TURN_CYC`=1 and `TURN_CYC`=4 builds: read `rsp_valid` latency shifts by exactly 3 clocks between the two builds.
